tpm_startup_sequencer: RTL

TPM_STARTUP_SEQUENCER -- requirements
Module: tpm_startup_sequencer

---
 rtl/tpm_startup_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tpm_startup_sequencer.sv
// TPM startup/shutdown sequencer: gates commands until Startup, classifies the startup type from NV state.
// Responses are held until rsp_ready; the optional locality check is enabled by STARTUP_LOCALITY_CHECK_EN.
module tpm_startup_sequencer #(
   parameter int unsigned NUM_HIER   = 3,
   parameter int unsigned NV_TIMEOUT = 255,
   parameter logic [7:0]  LOC_MASK   = 8'h1F
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                keyStart_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [31:0]         tpm_cc,
   input  logic [15:0]         cmd_param,
   input  logic [7:0]          locality,
   input  logic [15:0]         nv_orderly,
   input  logic [NUM_HIER-1:0] nv_hier_en,
   output logic                nv_rd_req,
   input  logic                nv_rd_ack,
   output logic                nv_wr_req,
   output logic [15:0]         shutdownSave,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         tpm_rc,
   output logic [2:0]          op_state,
   output logic [2:0]          startup_type,
   output logic [NUM_HIER-1:0] hier_en,
   output logic                fwd_valid
);
   localparam int unsigned CW = $clog2(NV_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NV_TIMEOUT - 1);

   localparam logic [2:0] S_RESET = 3'd0, S_INIT = 3'd1, S_STARTUP = 3'd2,
                          S_OPER  = 3'd3, S_SHUT = 3'd4, S_FAIL    = 3'd5;
   localparam logic [2:0] T_NONE  = 3'd0, T_RESET = 3'd1, T_RESTART = 3'd2,
                          T_RESUME = 3'd3, T_TYPE = 3'd4;
   localparam logic [31:0] CC_STARTUP = 32'h144, CC_SHUTDOWN = 32'h145;
   localparam logic [31:0] RC_SUCCESS = 32'h0, RC_INITIALIZE = 32'h100, RC_VALUE = 32'h84,
                           RC_FAILURE = 32'h101, RC_LOCALITY = 32'h907;

   logic [2:0]          state_q, state_d, type_q, type_d;
   logic [NUM_HIER-1:0] hier_q, hier_d, nvh_q, nvh_d;
   logic [31:0]         rc_q, rc_d;
   logic [15:0]         save_q, save_d;
   logic                rsp_vld_q, rsp_vld_d, rd_req_q, rd_req_d, wr_req_q, wr_req_d;
   logic                fwd_q, fwd_d, dec_q, dec_d, param_q, param_d, ord_q, ord_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                accept, param_ok, loc_ok;

   assign cmd_ready = ((state_q == S_INIT) || (state_q == S_OPER)) && !rsp_vld_q;
   assign accept    = cmd_valid && cmd_ready;
   assign param_ok  = (cmd_param == 16'h0) || (cmd_param == 16'h1);

`ifdef STARTUP_LOCALITY_CHECK_EN
   assign loc_ok = |(locality & LOC_MASK);
`else
   logic unused_loc;
   assign unused_loc = ^{locality, LOC_MASK};
   assign loc_ok     = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      hier_d    = hier_q;
      nvh_d     = nvh_q;
      rc_d      = rc_q;
      save_d    = save_q;
      rsp_vld_d = rsp_vld_q && !rsp_ready;
      rd_req_d  = rd_req_q;
      wr_req_d  = 1'b0;
      fwd_d     = 1'b0;
      dec_d     = 1'b0;
      cnt_d     = cnt_q;
      param_d   = param_q;
      ord_d     = ord_q;
      case (state_q)
         S_RESET: if (!keyStart_n) state_d = S_INIT;
         S_INIT: if (accept) begin
            rsp_vld_d = 1'b1;
            if (tpm_cc != CC_STARTUP) rc_d = RC_INITIALIZE;
            else if (!param_ok)       rc_d = RC_VALUE;
            else if (!loc_ok)         rc_d = RC_LOCALITY;
            else begin
               rsp_vld_d = 1'b0;
               state_d   = S_STARTUP;
               rd_req_d  = 1'b1;
               cnt_d     = '0;
               param_d   = cmd_param[0];
            end
         end
         S_STARTUP: begin
            // NV data is captured on ack and classified the following cycle
            if (dec_q) begin
               rsp_vld_d = 1'b1;
               if (!param_q) begin
                  type_d  = ord_q ? T_RESTART : T_RESET;
                  hier_d  = '1;
                  state_d = S_OPER;
                  rc_d    = RC_SUCCESS;
               end else if (ord_q) begin
                  type_d  = T_RESUME;
                  hier_d  = nvh_q;
                  state_d = S_OPER;
                  rc_d    = RC_SUCCESS;
               end else begin
                  type_d  = T_TYPE;
                  state_d = S_INIT;
                  rc_d    = RC_VALUE;
               end
            end else if (rd_req_q) begin
               if (nv_rd_ack) begin
                  rd_req_d = 1'b0;
                  dec_d    = 1'b1;
                  ord_d    = (nv_orderly == 16'h1);
                  nvh_d    = nv_hier_en;
               end else if (cnt_q == CNT_LAST) begin
                  rd_req_d  = 1'b0;
                  state_d   = S_FAIL;
                  rsp_vld_d = 1'b1;
                  rc_d      = RC_FAILURE;
                  hier_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_OPER: if (accept) begin
            if (tpm_cc == CC_STARTUP) begin
               rsp_vld_d = 1'b1;
               rc_d      = RC_INITIALIZE;
            end else if (tpm_cc == CC_SHUTDOWN) begin
               rsp_vld_d = 1'b1;
               if (!param_ok)    rc_d = RC_VALUE;
               else if (!loc_ok) rc_d = RC_LOCALITY;
               else begin
                  rc_d     = RC_SUCCESS;
                  wr_req_d = 1'b1;
                  save_d   = cmd_param;
                  state_d  = S_SHUT;
               end
            end else begin
               fwd_d = 1'b1;
            end
         end
         S_FAIL:  hier_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= S_RESET;
         type_q    <= T_NONE;
         hier_q    <= '0;
         nvh_q     <= '0;
         rc_q      <= '0;
         save_q    <= '0;
         rsp_vld_q <= 1'b0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         fwd_q     <= 1'b0;
         dec_q     <= 1'b0;
         cnt_q     <= '0;
         param_q   <= 1'b0;
         ord_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         hier_q    <= hier_d;
         nvh_q     <= nvh_d;
         rc_q      <= rc_d;
         save_q    <= save_d;
         rsp_vld_q <= rsp_vld_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         fwd_q     <= fwd_d;
         dec_q     <= dec_d;
         cnt_q     <= cnt_d;
         param_q   <= param_d;
         ord_q     <= ord_d;
      end
   end

   assign op_state     = state_q;
   assign startup_type = type_q;
   assign hier_en      = hier_q;
   assign tpm_rc       = rc_q;
   assign shutdownSave = save_q;
   assign rsp_valid    = rsp_vld_q;
   assign nv_rd_req    = rd_req_q;
   assign nv_wr_req    = wr_req_q;
   assign fwd_valid    = fwd_q;
endmodule
